// File: rtl/key_sched_pkg.sv
// rtl/key_sched_pkg.sv - shared types and constants for the key scheduler
package key_sched_pkg;

  localparam int KEY_W_DEF = 128;
  localparam logic [KEY_W_DEF-1:0] ZERO_SEED = '0;

  typedef enum logic [2:0] {
    S_UNSEEDED = 3'd0,
    S_LOAD     = 3'd1,
    S_WARMUP   = 3'd2,
    S_IDLE     = 3'd3,
    S_STEP     = 3'd4,
    S_DELIVER  = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  logic w_found;
  int   w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos = (int'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_scheduler.sv
// rtl/key_scheduler.sv - seeds, warms up and shares one LFSR key generator
module key_scheduler
  import key_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int KEY_W         = KEY_W_DEF,
  parameter int WARMUP_CYCLES = 256,
  parameter int STEP_CYCLES   = 128,
  parameter int CNT_W         = 9
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_seed_valid,
  input  logic [KEY_W-1:0]   in_seed,
  output logic               out_seed_ready,
  output logic               out_seed_err,
  output logic               out_seeded,
  input  logic [NUM_REQ-1:0] in_req,
  output logic [NUM_REQ-1:0] out_grant,
  output logic [KEY_W-1:0]   out_key,
  output logic               out_key_valid,
  input  logic               in_key_ready,
  output logic               out_lfsr_wr_seed,
  output logic [KEY_W-1:0]   out_lfsr_seed,
  output logic               out_lfsr_stop,
  input  logic [KEY_W-1:0]   in_lfsr_value
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [KEY_W-1:0]   r_seed;
  logic [IDX_W-1:0]   r_ptr, r_idx;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_seeded, r_seed_err;

  logic               w_seed_hs, w_seed_zero, w_cnt_done;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;

  assign w_seed_hs   = out_seed_ready & in_seed_valid;
  assign w_seed_zero = (in_seed == KEY_W'(ZERO_SEED));
  assign w_cnt_done  = (r_cnt == '0);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req   (in_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx)
  );

  always_comb begin
    w_next           = r_state;
    out_seed_ready   = 1'b0;
    out_lfsr_wr_seed = 1'b0;
    out_lfsr_stop    = 1'b1;
    out_key_valid    = 1'b0;
    case (r_state)
      S_UNSEEDED: begin
        out_seed_ready = 1'b1;
        if (w_seed_hs && !w_seed_zero) w_next = S_LOAD;
      end
      S_LOAD: begin
        out_lfsr_wr_seed = 1'b1;
        w_next           = S_WARMUP;
      end
      S_WARMUP: begin
        out_lfsr_stop = 1'b0;
        if (w_cnt_done) w_next = S_IDLE;
      end
      S_IDLE: begin
        out_seed_ready = 1'b1;
        // a zero seed still wins the cycle: it is consumed and dropped
        if (w_seed_hs) begin
          if (!w_seed_zero) w_next = S_LOAD;
        end else if (|in_req) begin
          w_next = S_STEP;
        end
      end
      S_STEP: begin
        out_lfsr_stop = 1'b0;
        if (w_cnt_done) w_next = S_DELIVER;
      end
      S_DELIVER: begin
        out_key_valid = 1'b1;
        if (in_key_ready) w_next = S_IDLE;
      end
      default: w_next = S_UNSEEDED;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state    <= S_UNSEEDED;
      r_cnt      <= '0;
      r_seed     <= '0;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_grant    <= '0;
      r_seeded   <= 1'b0;
      r_seed_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_seed_err <= w_seed_hs & w_seed_zero;
      if (w_seed_hs && !w_seed_zero) r_seed <= in_seed;

      if (w_next == S_WARMUP && r_state != S_WARMUP)
        r_cnt <= CNT_W'(WARMUP_CYCLES - 1);
      else if (w_next == S_STEP && r_state != S_STEP)
        r_cnt <= CNT_W'(STEP_CYCLES - 1);
      else if ((r_state == S_WARMUP || r_state == S_STEP) && !w_cnt_done)
        r_cnt <= r_cnt - 1'b1;

      if (r_state == S_WARMUP && w_cnt_done) r_seeded <= 1'b1;
      if (r_state == S_IDLE && w_next == S_LOAD) r_seeded <= 1'b0;

      if (r_state == S_IDLE && w_next == S_STEP) begin
        r_grant <= w_arb_grant;
        r_idx   <= w_arb_idx;
      end
      if (r_state == S_DELIVER && in_key_ready)
        r_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // generator is held in DELIVER, so its live value is already frozen
  assign out_key       = (r_state == S_DELIVER) ? in_lfsr_value : '0;
  assign out_grant     = (r_state == S_DELIVER) ? r_grant : '0;
  assign out_lfsr_seed = (r_state == S_LOAD) ? r_seed : '0;
  assign out_seeded    = r_seeded;
  assign out_seed_err  = r_seed_err;

endmodule

// File: tb/tb_key_scheduler.sv
// tb/tb_key_scheduler.sv - directed scoreboard bench for key_scheduler with an LFSR generator model
module tb_key_scheduler;

  localparam int NR = 4;
  localparam int KW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_valid = 1'b0;
  logic [KW-1:0] seed = '0;
  logic          seed_ready, seed_err, seeded;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] grant;
  logic [KW-1:0] key;
  logic          key_valid;
  logic          key_ready = 1'b0;
  logic          g_wr, g_stop;
  logic [KW-1:0] g_seed;
  logic [KW-1:0] g_lfsr = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [NR-1:0] g;
    logic [KW-1:0] k;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  key_scheduler dut (
    .in_clk           (clk),
    .in_rst           (rst),
    .in_seed_valid    (seed_valid),
    .in_seed          (seed),
    .out_seed_ready   (seed_ready),
    .out_seed_err     (seed_err),
    .out_seeded       (seeded),
    .in_req           (req),
    .out_grant        (grant),
    .out_key          (key),
    .out_key_valid    (key_valid),
    .in_key_ready     (key_ready),
    .out_lfsr_wr_seed (g_wr),
    .out_lfsr_seed    (g_seed),
    .out_lfsr_stop    (g_stop),
    .in_lfsr_value    (g_lfsr)
  );

  function automatic logic [KW-1:0] lfsr_step(input logic [KW-1:0] x);
    return {x[KW-2:0], x[127] ^ x[125] ^ x[100] ^ x[98]};
  endfunction

  function automatic logic [KW-1:0] lfsr_adv(input logic [KW-1:0] x, input int n);
    logic [KW-1:0] v = x;
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

  // key generator stand-in: load, step or hold; never reset
  always @(posedge clk) begin
    if (g_wr) g_lfsr <= g_seed;
    else if (!g_stop) g_lfsr <= lfsr_step(g_lfsr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!key_valid && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, KW'(key_valid), KW'(1));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, KW'(0), KW'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_grant"}, KW'(grant), KW'(e.g));
      chk({tag, "_key"}, key, e.k);
    end
  endtask

  task automatic run_seed(input logic [KW-1:0] s, input string tag);
    int wr_n = 0;
    int low_n = 0;
    for (int i = 0; i < 400 && !seeded; i++) begin
      if (g_wr) wr_n++;
      if (!g_stop) low_n++;
      tick();
    end
    chk({tag, "_wr_cycles"}, KW'(wr_n), KW'(1));
    chk({tag, "_stop_low"}, KW'(low_n), KW'(256));
    chk({tag, "_seeded"}, KW'(seeded), KW'(1));
    chk({tag, "_lfsr"}, g_lfsr, lfsr_adv(s, 256));
  endtask

  initial begin
    logic [KW-1:0] model;
    logic [KW-1:0] hold_key;
    logic [NR-1:0] hold_grant;
    int bad;
    int last_cyc;

    // 1: reset, requests ignored while unseeded
    tick();
    tick();
    rst = 1'b0;
    req = 4'b0001;
    tick();
    chk("rst_seed_ready", KW'(seed_ready), KW'(1));
    chk("rst_stop", KW'(g_stop), KW'(1));
    chk("rst_outs", KW'({seeded, seed_err, key_valid, grant, g_wr}), KW'(0));
    chk("rst_key", key, '0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (key_valid !== 1'b0 || grant !== '0 || g_stop !== 1'b1) bad++;
      tick();
    end
    chk("unseeded_idle", KW'(bad), KW'(0));
    req = '0;

    // 2: seed and warm up
    seed_valid = 1'b1;
    seed = 128'h1;
    tick();
    seed_valid = 1'b0;
    run_seed(128'h1, "seed1");
    model = lfsr_adv(128'h1, 256);

    // 3: round-robin service with back-to-back keys
    req = 4'b1111;
    key_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      model = lfsr_adv(model, 128);
      e.g = NR'(1) << (k % NR);
      e.k = model;
      sb.push_back(e);
    end
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_valid("rr");
      pop_check("rr");
      if (k > 0) chk("rr_spacing", KW'(cyc - last_cyc), KW'(130));
      last_cyc = cyc;
      if (k == 4) req = '0;
      tick();
    end
    chk("rr_back_idle", KW'(seed_ready), KW'(1));

    // 4: stalled delivery; requester drops its request mid-service
    key_ready = 1'b0;
    req = 4'b0100;
    tick();
    req = '0;
    begin
      exp_t e;
      model = lfsr_adv(model, 128);
      e.g = 4'b0100;
      e.k = model;
      sb.push_back(e);
    end
    wait_valid("stall");
    pop_check("stall");
    hold_key = key;
    hold_grant = grant;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (key !== hold_key || grant !== hold_grant || key_valid !== 1'b1 || g_stop !== 1'b1) bad++;
    end
    chk("stall_stable", KW'(bad), KW'(0));
    key_ready = 1'b1;
    tick();
    chk("stall_release", KW'({key_valid, seed_ready}), KW'(2'b01));

    // 5: seed beats a same-cycle request; zero seed is rejected
    seed_valid = 1'b1;
    seed = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    req = 4'b0010;
    tick();
    seed_valid = 1'b0;
    req = '0;
    chk("reseed_load", KW'({g_wr, seeded}), KW'(2'b10));
    chk("reseed_no_grant", KW'(grant), KW'(0));
    run_seed(128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA, "seed2");
    model = lfsr_adv(128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA, 256);
    seed_valid = 1'b1;
    seed = '0;
    tick();
    seed_valid = 1'b0;
    chk("zero_err_pulse", KW'({seed_err, seeded, g_wr}), KW'(3'b110));
    tick();
    chk("zero_err_clear", KW'({seed_err, seeded, seed_ready}), KW'(3'b011));
    req = 4'b0010;
    begin
      exp_t e;
      model = lfsr_adv(model, 128);
      e.g = 4'b0010;
      e.k = model;
      sb.push_back(e);
    end
    tick();
    req = '0;
    wait_valid("post_zero");
    pop_check("post_zero");
    tick();

    // 6: reset in the middle of STEP
    req = 4'b0001;
    tick();
    req = '0;
    for (int i = 0; i < 49; i++) tick();
    chk("mid_step_stop", KW'(g_stop), KW'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_outs", KW'({key_valid, grant, seeded}), KW'(0));
    chk("rst_mid_stop", KW'({g_stop, seed_ready}), KW'(2'b11));
    tick();
    chk("rst_mid_hold", KW'({g_stop, key_valid, seeded}), KW'(3'b100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
